// File: rtl/mc_ctrl_fsm_if.sv
// Control bus between the instruction register / conditional-logic stage and
// the multicycle main controller. The controller sits on the slave side.
interface mc_ctrl_fsm_if;
  // instruction fields, taken combinationally from the IR
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  // requests to the conditional-logic stage
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic [1:0] FlagW;
  // datapath strobes and mux selects
  logic       NextPC;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;

  modport slave (
    input  Op, Funct, Rd,
    output PCS, RegW, MemW, FlagW, NextPC, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
  );

  modport master (
    output Op, Funct, Rd,
    input  PCS, RegW, MemW, FlagW, NextPC, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle main controller: ten-state Moore FSM plus ALU decoder and
// PC-source logic. Instruction fields are never registered here; they are
// read straight from the IR every cycle.
module mc_ctrl_fsm (
  input  logic          clk,
  input  logic          reset,
  mc_ctrl_fsm_if.slave  bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  // per-state decode of the Moore outputs
  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       aluop;
  } ctrl_t;

  state_e     state_q, state_d;
  ctrl_t      ctrl;
  logic [3:0] cmd;
  logic       is_cmp;
  logic [1:0] alu_ctl;
  logic [1:0] flag_w;
  logic       pcs;

  assign cmd    = bus.Funct[4:1];
  assign is_cmp = (cmd == 4'b1010);

  // state register; reset wins from any state
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;   // undefined opcode is silently dropped
        endcase
      end
      S_MEMADR:   state_d = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH: state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode; everything not named for a state stays zero
  always_comb begin
    ctrl = '0;
    unique case (state_q)
      S_FETCH: begin
        ctrl.irwrite   = 1'b1;
        ctrl.nextpc    = 1'b1;
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = 2'b10;
        ctrl.resultsrc = 2'b10;
      end
      S_DECODE: begin
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = 2'b10;
        ctrl.resultsrc = 2'b10;
      end
      S_MEMADR:   ctrl.alusrcb = 2'b01;
      S_MEMREAD:  ctrl.adrsrc  = 1'b1;
      S_MEMWB: begin
        ctrl.resultsrc = 2'b01;
        ctrl.regw      = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adrsrc = 1'b1;
        ctrl.memw   = 1'b1;
      end
      S_EXECUTER: ctrl.aluop = 1'b1;
      S_EXECUTEI: begin
        ctrl.alusrcb = 2'b01;
        ctrl.aluop   = 1'b1;
      end
      // compares only update flags, so the writeback is suppressed
      S_ALUWB:    ctrl.regw = ~is_cmp;
      S_BRANCH: begin
        ctrl.alusrcb   = 2'b01;
        ctrl.resultsrc = 2'b10;
        ctrl.branch    = 1'b1;
      end
      default:    ctrl = '0;
    endcase
  end

  // ALU decoder: operation and flag-write enables in the execute states
  always_comb begin
    alu_ctl = 2'b00;
    flag_w  = 2'b00;
    if (ctrl.aluop) begin
      unique case (cmd)
        4'b0100: alu_ctl = 2'b00;   // ADD
        4'b0010: alu_ctl = 2'b01;   // SUB
        4'b0000: alu_ctl = 2'b10;   // AND
        4'b1100: alu_ctl = 2'b11;   // ORR
        4'b1010: alu_ctl = 2'b01;   // CMP subtracts
        default: alu_ctl = 2'b00;
      endcase
      // C/V only make sense for arithmetic ops
      flag_w[1] = bus.Funct[0];
      flag_w[0] = bus.Funct[0] & ~alu_ctl[1];
    end
  end

  // writes to R15 redirect the PC just like a branch
  assign pcs = (ctrl.regw & (bus.Rd == 4'hF)) | ctrl.branch;

  // architectural side effects are squashed while reset is held
  assign bus.PCS        = pcs          & ~reset;
  assign bus.RegW       = ctrl.regw    & ~reset;
  assign bus.MemW       = ctrl.memw    & ~reset;
  assign bus.IRWrite    = ctrl.irwrite & ~reset;
  assign bus.NextPC     = ctrl.nextpc  & ~reset;
  assign bus.FlagW      = reset ? 2'b00 : flag_w;
  assign bus.AdrSrc     = ctrl.adrsrc;
  assign bus.ResultSrc  = ctrl.resultsrc;
  assign bus.ALUSrcA    = ctrl.alusrca;
  assign bus.ALUSrcB    = ctrl.alusrcb;
  assign bus.ALUControl = alu_ctl;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};

endmodule
